// File: rtl/addr_decode_pkg.sv
// Shared types and helpers for the wait-state address decoder.
// Holds the access state encoding, region-count derivation and one-hot builder.
package addr_decode_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Upper bound on regions the one-hot helper can express (SEL_BITS <= 6).
    localparam int MAX_NREG = 64;

    function automatic int nreg_of(input int sel_bits);
        return 1 << sel_bits;
    endfunction

    function automatic logic [MAX_NREG-1:0] onehot(input int unsigned idx);
        return MAX_NREG'(1) << idx;
    endfunction

endpackage

// File: rtl/addr_decode_ws_ws_counter.sv
// Loadable down-counter used to time wait states; stops at zero and flags it.
module ws_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load wins over decrement; the count saturates at zero rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/addr_decode_ws.sv
// Clocked chip-select decoder with per-region wait states, ready pulse and
// registered read-data return from the selected slave.
module addr_decode_ws
    import addr_decode_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int SEL_BITS = 2,
    parameter int WS_W     = 4,
    parameter logic [nreg_of(SEL_BITS)*WS_W-1:0] WAIT_STATES = '0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req,
    input  logic                                  we,
    input  logic [ADDR_W-1:0]                     addr,
    output logic [nreg_of(SEL_BITS)-1:0]          cs,
    output logic                                  we_o,
    output logic [ADDR_W-1:0]                     addr_o,
    input  logic [nreg_of(SEL_BITS)*DATA_W-1:0]   rdata_in,
    output logic [DATA_W-1:0]                     rdata,
    output logic                                  ready,
    output logic                                  busy
);

    localparam int NREG = nreg_of(SEL_BITS);

    state_t              state;
    state_t              state_nx;
    logic                start;
    logic                finish;
    logic                cnt_zero;
    logic [SEL_BITS-1:0] region;
    logic [SEL_BITS-1:0] region_q;
    logic [WS_W-1:0]     ws_load;
    logic [NREG-1:0]     cs_load;

    assign region  = addr[ADDR_W-1 -: SEL_BITS];
    assign ws_load = WAIT_STATES[int'(region)*WS_W +: WS_W];
    assign cs_load = NREG'(onehot(32'(region)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // req is only honoured in IDLE or DONE; DONE restarts directly for back-to-back access.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    start    = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (req) begin
                    start    = 1'b1;
                    state_nx = ACCESS;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    ws_counter #(
        .W (WS_W)
    ) u_ws_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .load_val (ws_load),
        .dec      (state == ACCESS),
        .zero     (cnt_zero)
    );

    // Slave-side registers; leaving DONE without a new request returns them to idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs       <= '0;
            we_o     <= 1'b0;
            addr_o   <= '0;
            region_q <= '0;
            rdata    <= '0;
        end else if (start) begin
            cs       <= cs_load;
            we_o     <= we;
            addr_o   <= addr;
            region_q <= region;
        end else if (finish) begin
            cs <= '0;
            if (!we_o) begin
                rdata <= rdata_in[int'(region_q)*DATA_W +: DATA_W];
            end
        end else if (state == DONE) begin
            we_o   <= 1'b0;
            addr_o <= '0;
        end
    end

    assign ready = (state == DONE);
    assign busy  = (state == ACCESS);

endmodule

// File: doc/addr_decode_ws.md
Name: addr_decode_ws

Overview:
- Parametrised, clocked successor to the 4-way combinational chip-select decoder.
- Decodes the top SEL_BITS of the CPU address into 2^SEL_BITS one-hot registered chip-selects.
- Inserts a per-region programmable number of wait states and returns a one-cycle ready handshake.
- Muxes and registers read data from the selected region back to the CPU.
- Sits between the CPU bus master and the memory/peripheral slaves.

Parameters:
- ADDR_W, 16, CPU address width.
- DATA_W, 16, data bus width.
- SEL_BITS, 2, number of top address bits used for decode; NREG = 2**SEL_BITS regions.
- WS_W, 4, width of one wait-state count.
- WAIT_STATES, {NREG{WS_W'(0)}}, packed per-region wait-state counts; region r uses bits [r*WS_W +: WS_W].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  access strobe from CPU, sampled only in IDLE or DONE.
- we  input  1  write enable qualifying req.
- addr  input  ADDR_W  CPU address, sampled with req.
- cs  output  NREG  registered one-hot chip-selects.
- we_o  output  1  registered write enable to slaves; valid while any cs is high.
- addr_o  output  ADDR_W  latched address to slaves.
- rdata_in  input  NREG*DATA_W  packed slave read data; region r is at [r*DATA_W +: DATA_W].
- rdata  output  DATA_W  registered read data to CPU.
- ready  output  1  one-cycle access-complete pulse.
- busy  output  1  high in ACCESS state.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, cs=0, we_o=0, addr_o=0, rdata=0, ready=0, busy=0, cnt=0.
- States: IDLE, ACCESS, DONE.

IDLE:
- If req=1: latch addr into addr_o and we into we_o.
- Set region = addr[ADDR_W-1 -: SEL_BITS].
- Load cnt with WAIT_STATES[region].
- Set cs to one-hot(region) and go to ACCESS.
- If req=0: stay in IDLE; all outputs hold their reset values, except rdata, which holds its last value.

ACCESS:
- busy=1 and cs held.
- If cnt!=0: decrement cnt.
- If cnt==0:
  - If we_o=0, capture rdata from the selected region's slice of rdata_in.
  - Clear cs, set ready=1, go to DONE.

DONE:
- ready=1 for exactly this cycle; cs=0; rdata valid.
- If req=1: start a new access exactly as from IDLE (back-to-back, no idle bubble).
- Else: go to IDLE and clear we_o.

Timing and handshake:
- Latency from req sampled to ready high is 2 + WAIT_STATES[region] cycles.
- cs is high for 1 + WAIT_STATES[region] cycles.
- req in ACCESS is ignored: no queueing, no error. The master must not issue req until ready.
- Writes: rdata is not updated.
- Exactly one cs bit is ever high; cs is never high in IDLE or DONE.

Boundary conditions:
- WAIT_STATES = max (2**WS_W - 1): count completes without wrap.
- Region index NREG-1 (all-ones top bits) decodes correctly.
- SEL_BITS=1 gives 2 regions.
- Reset asserted mid-ACCESS: cs drops immediately (asynchronously). The access is abandoned and no ready is issued.

Decomposition:
- Shared package addr_decode_pkg holds:
  - the state enum (IDLE/ACCESS/DONE);
  - localparam NREG derivation;
  - a one-hot helper function.
- One natural sub-module: ws_counter, a loadable down-counter with a zero flag, WS_W wide.
- Decode logic and read-data mux stay inline.

Test Plan:
- Reset then idle: all outputs 0 after rst_n deassert; no cs for 10 cycles with req=0.
- Read, WAIT_STATES all 0, addr=16'h4010:
  - cs=4'b0010 for 1 cycle; ready at cycle 2;
  - rdata = rdata_in slice 1 (drive 16'hBEEF) → rdata=16'hBEEF.
- Region 2 WAIT_STATES=3, write to addr=16'h8000:
  - cs=4'b0100 for 4 cycles, we_o=1; ready at cycle 5; rdata unchanged.
- Back-to-back: req held high through DONE, addresses 16'h0000 then 16'hC000:
  - cs=4'b0001 then 4'b1000 with no IDLE cycle between;
  - two ready pulses.
- req pulsed during ACCESS with WAIT_STATES=2: ignored; exactly one ready.
- rst_n low in the 2nd ACCESS cycle of a 3-wait access: cs=0 immediately; no ready; state IDLE after release.
